ps2_tx: RTL and testbench
=========================

# ps2_tx

Host-to-device PS/2 transmitter: it sends command bytes from the CPU to the keyboard, such as set-LEDs (0xED) or enable-scanning (0xF4). It is the opposite direction of the receive-only `ps2` block. It sits on the `mmapper` peripheral bus beside `ps2`, shares the `ps2_clk`/`ps2_data` pins through open-drain enables, and raises `irq` when a transfer completes or fails.

## Interface
- `CLOCK_FREQ`, 62500000: clk frequency in Hz.
- `INHIBIT_US`, 120: duration in µs that clock is held low before the request.
- `TIMEOUT_US`, 20000: maximum gap in µs between device clock falling edges.
- `FILTER_CYC`, 8: number of cycles an input must be stable before the filtered value updates.
- `clk` in 1: system clock (`clk_main`).
- `rst` in 1: synchronous, active-high reset.
- `a` in 3: register address.
- `d` in 32: write data.
- `we` in 1: write strobe, one cycle.
- `spo` out 32: combinational read data for address `a`.
- `kclk_i` in 1: raw PS/2 clock pin level.
- `kdata_i` in 1: raw PS/2 data pin level.
- `kclk_oe` out 1: 1 drives the clock pin low; 0 releases it.
- `kdata_oe` out 1: 1 drives the data pin low; 0 releases it.
- `busy` out 1: high while a transfer is in progress; a receiver may use it to mask its input.
- `irq` out 1: level, equal to `done | err`.

## Operation
- Register map:
  - a=0, write: `d[7:0]` starts a transfer when IDLE. The write is ignored when busy.
  - a=0, read: `{24'b0, last_tx_byte}`.
  - a=1, read: `{28'b0, nack, err, done, busy}`.
  - a=1, write with `d[1]` set: clears done, err and nack.
  - Other addresses read 0 and ignore writes.
- Input conditioning: each input passes through a 2-FF synchronizer, then a stability filter of `FILTER_CYC` cycles. `fall` is a one-cycle pulse when filtered clock goes 1→0.
- Frame: start bit 0, data[0..7] LSB first, odd parity (`~^data`), stop bit 1 (line released), then the device ACK bit.
- FSM states:
  - IDLE: both oe=0. A write to a=0 latches the byte, clears done/err/nack, and goes to INHIBIT.
  - INHIBIT: `kclk_oe=1` for `INHIBIT_CYC = CLOCK_FREQ/1e6*INHIBIT_US` cycles, then REQ.
  - REQ: `kclk_oe=1`, `kdata_oe=1` for 16 cycles, then SHIFT. In SHIFT the clock is released and data is held low as the start bit.
  - SHIFT: bit counter 0..9. On each `fall`, drive the next bit with `kdata_oe = ~bit`: falls 1–8 drive data bits, fall 9 drives parity, fall 10 releases data for the stop bit. After fall 10, go to ACK.
  - ACK: on the next `fall`, sample filtered data. 0 is a valid ACK; 1 sets nack. Then go to WAIT.
  - WAIT: wait until filtered clock and data are both 1, then set done and go to IDLE.
- Timeout: a counter runs in SHIFT, ACK and WAIT and restarts on every `fall`. Reaching `TIMEOUT_CYC` sets err, releases both lines and returns to IDLE; done stays 0.
- `busy` = (state != IDLE).

## Timing
- Reset values: `kclk_oe=0`, `kdata_oe=0`, `busy=0`, `irq=0`, state=IDLE, `last_tx_byte=0`, done/err/nack=0, counters 0.
- The cycle after a write to a=0 in IDLE: `busy=1` and `kclk_oe=1`.
- Pin-to-`fall` latency: 2 sync cycles + `FILTER_CYC` + 1.
- `kdata_oe` updates exactly one cycle after `fall`.
- done/err set in the same cycle the FSM returns to IDLE. `irq` follows in the same cycle.
- A status clear and a done/err set in the same cycle: the set wins.
- Reset asserted mid-transfer: both oe are released on the next edge, with no partial frame completion.
- Writes to a=0 while busy: no effect on state or `last_tx_byte`.

## Structure
- Shared package `ps2_pkg`: the FSM state enum, the register offsets (`PS2TX_DATA=0`, `PS2TX_STAT=1`) and the status bit indices.
- `INHIBIT_CYC` and `TIMEOUT_CYC` are localparams derived in the module.
- One sub-module, `ps2_line_filter`: 2-FF sync plus stability filter, instantiated once for clock and once for data. It can be reused by `ps2`.

## Test plan
- Write 0xED with a device model clocking at 12.5 kHz and ACKing. Required: inhibit lasts ≥120 µs; bits sampled on device rising edges are 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done=1, nack=0, irq=1; reading a=1 returns 0x2.
- Write 0xF4. Required: parity 0. Then write a=1 with d=0x2: irq drops the next cycle and status reads 0.
- Device withholds ACK (data stays 1 on the 11th clock). Required: nack=1 and done=1, so a=1 reads 0xA.
- Device stops clocking after 4 bits. Required: after 20 ms, err=1, both oe=0, busy=0, and a=1 reads 0x4.
- Write 0x12 during a transfer of 0x55, then assert rst mid-frame. Required: a=0 still reads 0x55 before reset; after reset, oe=0, busy=0 and a=0 reads 0.
- A 3-cycle glitch on `kclk_i` during SHIFT. Required: no bit advance and no extra `fall`.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host-side blocks.
//   - ps2_tx_state_t : transmitter FSM state encoding
//   - PS2TX_DATA/STAT: register offsets on the peripheral bus
//   - STAT_*         : bit positions inside the status register
//   - ps2_frame_bits : the 10 bits driven after the start bit
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_REQ     = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_WAIT    = 3'd5
    } ps2_tx_state_t;

    localparam logic [2:0] PS2TX_DATA = 3'd0;
    localparam logic [2:0] PS2TX_STAT = 3'd1;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_NACK = 3;

    // Cycles both lines are held low before the clock is released.
    localparam int REQ_CYC = 16;

    // Bits sent on device clock falls 1..10: data LSB first, odd parity,
    // stop (1 = line released).
    function automatic logic [9:0] ps2_frame_bits(input logic [7:0] data);
        return {1'b1, ~^data, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: conditions one raw PS/2 pin.
//   clk, rst : system clock, synchronous active-high reset
//   i_pin    : raw pin level (asynchronous)
//   o_level  : synchronized level, updated only after FILTER_CYC stable cycles
//   o_fall   : one-cycle pulse when o_level goes 1 -> 0
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall
);

    localparam int CW = (FILTER_CYC > 1) ? $clog2(FILTER_CYC) : 1;

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    // Idle PS/2 lines are pulled high, so everything resets to 1 to avoid
    // a spurious fall right after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_pin;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Count consecutive samples that disagree with the filtered
            // level; any agreeing sample restarts the count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILTER_CYC - 1)) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_level_d & ~r_level;

endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: host-to-device PS/2 transmitter on the peripheral bus.
//   clk, rst          : system clock, synchronous active-high reset
//   a, d, we          : register address, write data, one-cycle write strobe
//   spo               : combinational read data for address a
//   kclk_i, kdata_i   : raw PS/2 pin levels
//   kclk_oe, kdata_oe : 1 pulls the corresponding open-drain pin low
//   busy              : transfer in progress
//   irq               : done | err
//   dbg_state         : current FSM state, for observation only
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int CLOCK_FREQ = 62500000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_US = 20000,
    parameter int FILTER_CYC = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    a,
    input  logic [31:0]   d,
    input  logic          we,
    output logic [31:0]   spo,
    input  logic          kclk_i,
    input  logic          kdata_i,
    output logic          kclk_oe,
    output logic          kdata_oe,
    output logic          busy,
    output logic          irq,
    output ps2_tx_state_t dbg_state
);

    // 64-bit intermediate keeps fractional-MHz clocks exact.
    localparam int INHIBIT_CYC = int'((longint'(CLOCK_FREQ) * INHIBIT_US) / 1000000);
    localparam int TIMEOUT_CYC = int'((longint'(CLOCK_FREQ) * TIMEOUT_US) / 1000000);

    ps2_tx_state_t r_state, w_state_n;
    logic [31:0]   r_cnt, w_cnt_n;
    logic [31:0]   r_tmo, w_tmo_n;
    logic [3:0]    r_bitcnt, w_bitcnt_n;
    logic [7:0]    r_byte, w_byte_n;
    logic          r_kdata_oe, w_kdata_oe_n;
    logic          r_done, w_done_n;
    logic          r_err, w_err_n;
    logic          r_nack, w_nack_n;

    logic          w_kclk;
    logic          w_kclk_fall;
    logic          w_kdata;
    logic          w_kdata_fall_unused;
    logic          w_wr_data;
    logic          w_clr;
    logic [9:0]    w_frame;
    logic          w_unused_d;

    ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_clk_filt (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (kclk_i),
        .o_level (w_kclk),
        .o_fall  (w_kclk_fall)
    );

    ps2_line_filter #(.FILTER_CYC(FILTER_CYC)) u_data_filt (
        .clk     (clk),
        .rst     (rst),
        .i_pin   (kdata_i),
        .o_level (w_kdata),
        .o_fall  (w_kdata_fall_unused)
    );

    assign w_wr_data  = we && (a == PS2TX_DATA);
    assign w_clr      = we && (a == PS2TX_STAT) && d[1];
    assign w_frame    = ps2_frame_bits(r_byte);
    assign w_unused_d = ^d[31:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_bitcnt   <= '0;
            r_byte     <= '0;
            r_kdata_oe <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_tmo      <= w_tmo_n;
            r_bitcnt   <= w_bitcnt_n;
            r_byte     <= w_byte_n;
            r_kdata_oe <= w_kdata_oe_n;
            r_done     <= w_done_n;
            r_err      <= w_err_n;
            r_nack     <= w_nack_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_tmo_n      = '0;
        w_bitcnt_n   = r_bitcnt;
        w_byte_n     = r_byte;
        w_kdata_oe_n = r_kdata_oe;
        w_done_n     = r_done;
        w_err_n      = r_err;
        w_nack_n     = r_nack;

        // Clear first so that a flag set below in the same cycle wins.
        if (w_clr) begin
            w_done_n = 1'b0;
            w_err_n  = 1'b0;
            w_nack_n = 1'b0;
        end

        unique case (r_state)
            ST_IDLE: begin
                w_kdata_oe_n = 1'b0;
                w_cnt_n      = '0;
                w_bitcnt_n   = '0;
                if (w_wr_data) begin
                    w_byte_n  = d[7:0];
                    w_done_n  = 1'b0;
                    w_err_n   = 1'b0;
                    w_nack_n  = 1'b0;
                    w_state_n = ST_INHIBIT;
                end
            end

            ST_INHIBIT: begin
                if (r_cnt == 32'(INHIBIT_CYC - 1)) begin
                    w_cnt_n      = '0;
                    w_kdata_oe_n = 1'b1;
                    w_state_n    = ST_REQ;
                end else begin
                    w_cnt_n = r_cnt + 32'd1;
                end
            end

            // Data stays low on leaving REQ: that is the start bit.
            ST_REQ: begin
                if (r_cnt == 32'(REQ_CYC - 1)) begin
                    w_cnt_n   = '0;
                    w_state_n = ST_SHIFT;
                end else begin
                    w_cnt_n = r_cnt + 32'd1;
                end
            end

            ST_SHIFT: begin
                w_tmo_n = w_kclk_fall ? 32'd0 : r_tmo + 32'd1;
                if (w_kclk_fall) begin
                    w_kdata_oe_n = ~w_frame[r_bitcnt];
                    if (r_bitcnt == 4'd9) begin
                        w_bitcnt_n = '0;
                        w_state_n  = ST_ACK;
                    end else begin
                        w_bitcnt_n = r_bitcnt + 4'd1;
                    end
                end
            end

            ST_ACK: begin
                w_tmo_n = w_kclk_fall ? 32'd0 : r_tmo + 32'd1;
                if (w_kclk_fall) begin
                    if (w_kdata) begin
                        w_nack_n = 1'b1;
                    end
                    w_state_n = ST_WAIT;
                end
            end

            ST_WAIT: begin
                w_tmo_n = w_kclk_fall ? 32'd0 : r_tmo + 32'd1;
                if (w_kclk && w_kdata) begin
                    w_done_n  = 1'b1;
                    w_state_n = ST_IDLE;
                end
            end

            default: begin
                w_kdata_oe_n = 1'b0;
                w_state_n    = ST_IDLE;
            end
        endcase

        // A stalled device aborts the frame; this overrides any completion
        // decided above in the same cycle.
        if (((r_state == ST_SHIFT) || (r_state == ST_ACK) || (r_state == ST_WAIT))
            && !w_kclk_fall && (r_tmo == 32'(TIMEOUT_CYC - 1))) begin
            w_err_n      = 1'b1;
            w_done_n     = 1'b0;
            w_kdata_oe_n = 1'b0;
            w_bitcnt_n   = '0;
            w_tmo_n      = '0;
            w_state_n    = ST_IDLE;
        end
    end

    always_comb begin
        spo = '0;
        case (a)
            PS2TX_DATA: spo = {24'b0, r_byte};
            PS2TX_STAT: begin
                spo[STAT_BUSY] = busy;
                spo[STAT_DONE] = r_done;
                spo[STAT_ERR]  = r_err;
                spo[STAT_NACK] = r_nack;
            end
            default: spo = '0;
        endcase
    end

    assign kclk_oe   = (r_state == ST_INHIBIT) || (r_state == ST_REQ);
    assign kdata_oe  = r_kdata_oe;
    assign busy      = (r_state != ST_IDLE);
    assign irq       = r_done | r_err;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_ps2_tx.sv
module tb_ps2_tx;
    import ps2_pkg::*;

    localparam int CLOCK_FREQ = 1000000;
    localparam int INHIBIT_US = 20;
    localparam int TIMEOUT_US = 400;
    localparam int FILTER_CYC = 4;
    localparam int INH_CYC    = CLOCK_FREQ / 1000000 * INHIBIT_US;
    localparam int TMO_CYC    = CLOCK_FREQ / 1000000 * TIMEOUT_US;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT ----------------
    logic [2:0]    a  = '0;
    logic [31:0]   d  = '0;
    logic          we = 1'b0;
    logic [31:0]   spo;
    logic          kclk_i, kdata_i;
    logic          kclk_oe, kdata_oe, busy, irq;
    ps2_tx_state_t dbg_state;

    // Device side of the open-drain bus.
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    assign kclk_i  = dev_clk & ~kclk_oe;
    assign kdata_i = dev_data & ~kdata_oe;

    ps2_tx #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .INHIBIT_US (INHIBIT_US),
        .TIMEOUT_US (TIMEOUT_US),
        .FILTER_CYC (FILTER_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .d         (d),
        .we        (we),
        .spo       (spo),
        .kclk_i    (kclk_i),
        .kdata_i   (kdata_i),
        .kclk_oe   (kclk_oe),
        .kdata_oe  (kdata_oe),
        .busy      (busy),
        .irq       (irq),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [10:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Line image seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            f[i + 1] = b[i];
            ones += int'(b[i]);
        end
        f[9]  = (ones % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wr(input logic [2:0] addr, input logic [31:0] val);
        @(posedge clk); #1;
        a = addr; d = val; we = 1'b1;
        @(posedge clk); #1;
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] addr, output logic [31:0] val);
        @(negedge clk);
        a = addr;
        #1 val = spo;
    endtask

    // Waits for the request-to-send (clock released, data low) and counts
    // inhibit cycles (clock low, data released) on the way.
    task automatic wait_rts(output int inh, output bit ok);
        inh = 0;
        ok  = 1'b0;
        for (int i = 0; i < INH_CYC + 200; i++) begin
            @(negedge clk);
            if (kclk_oe && !kdata_oe) inh++;
            if (busy && !kclk_oe && kdata_oe) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Device clock generator; samples the line just before each rising edge.
    task automatic dev_run(input int half, input int nclk, input bit ack,
                           input int glitch_at, output logic [10:0] fr);
        fr = '0;
        repeat (half) @(negedge clk);
        fr[0] = kdata_i;
        for (int k = 1; k <= nclk && k <= 10; k++) begin
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            fr[k] = kdata_i;
            dev_clk = 1'b1;
            if (k == glitch_at) begin
                repeat (10) @(negedge clk);
                dev_clk = 1'b0;
                repeat (3) @(negedge clk);
                dev_clk = 1'b1;
                repeat (half - 13) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
        end
        if (nclk >= 11) begin
            if (ack) dev_data = 1'b0;
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            repeat (half) @(negedge clk);
            dev_clk = 1'b1;
            repeat (half) @(negedge clk);
            dev_data = 1'b1;
        end
    endtask

    task automatic wait_idle(input int limit, output int cyc);
        cyc = 0;
        while (busy && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // One complete transfer checked against the reference frame and status.
    task automatic do_xfer(input string tag, input logic [7:0] b, input int half,
                           input bit ack, input int glitch_at, output logic [10:0] fr);
        int inh, cyc;
        bit ok;
        logic [31:0] v;
        logic [10:0] exp;
        exp_q.push_back(ref_frame(b));
        wr(PS2TX_DATA, {24'b0, b});
        check({tag, "_start"}, {30'b0, busy, kclk_oe}, 32'h3);
        wait_rts(inh, ok);
        check({tag, "_rts"}, {31'b0, ok}, 32'h1);
        check({tag, "_inhibit"}, {31'b0, (inh >= INH_CYC)}, 32'h1);
        dev_run(half, 11, ack, glitch_at, fr);
        exp = exp_q.pop_front();
        check({tag, "_frame"}, {21'b0, fr}, {21'b0, exp});
        wait_idle(300, cyc);
        check({tag, "_idle"}, {31'b0, busy}, 32'h0);
        rd(PS2TX_STAT, v);
        check({tag, "_stat"}, v, {28'b0, ~ack, 1'b0, 1'b1, 1'b0});
        check({tag, "_irq"}, {31'b0, irq}, 32'h1);
        rd(PS2TX_DATA, v);
        check({tag, "_last"}, v, {24'b0, b});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] v;
        logic [10:0] fr;
        int inh, cyc;
        bit ok;
        logic [7:0] rb;
        bit rack;

        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_oe", {30'b0, kclk_oe, kdata_oe}, 32'h0);
        check("rst_busy_irq", {30'b0, busy, irq}, 32'h0);
        rd(PS2TX_DATA, v);
        check("rst_data", v, 32'h0);
        rd(PS2TX_STAT, v);
        check("rst_stat", v, 32'h0);

        // Set-LEDs command with ACK.
        do_xfer("ed", 8'hED, 20, 1'b1, 0, fr);
        check("ed_parity", {31'b0, fr[9]}, 32'h1);
        check("ed_stop", {31'b0, fr[10]}, 32'h1);

        // Enable-scanning, then clear status.
        do_xfer("f4", 8'hF4, 24, 1'b1, 0, fr);
        check("f4_parity", {31'b0, fr[9]}, 32'h0);
        wr(PS2TX_STAT, 32'h2);
        check("clr_irq", {31'b0, irq}, 32'h0);
        rd(PS2TX_STAT, v);
        check("clr_stat", v, 32'h0);

        // Device withholds ACK.
        do_xfer("nack", 8'hA5, 22, 1'b0, 0, fr);
        wr(PS2TX_STAT, 32'h2);

        // Device stops clocking after 4 bits.
        wr(PS2TX_DATA, 32'h3C);
        wait_rts(inh, ok);
        check("tmo_rts", {31'b0, ok}, 32'h1);
        dev_run(20, 4, 1'b1, 0, fr);
        wait_idle(TMO_CYC + 200, cyc);
        check("tmo_not_early", {31'b0, (cyc > TMO_CYC / 2)}, 32'h1);
        check("tmo_lines", {29'b0, busy, kclk_oe, kdata_oe}, 32'h0);
        rd(PS2TX_STAT, v);
        check("tmo_stat", v, 32'h4);
        check("tmo_irq", {31'b0, irq}, 32'h1);

        // 3-cycle clock glitch while shifting must not advance the frame.
        do_xfer("glitch", 8'h96, 25, 1'b1, 3, fr);

        // Randomized transfers.
        for (int n = 0; n < 8; n++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            do_xfer($sformatf("rnd%0d", n), rb, $urandom_range(15, 30), rack, 0, fr);
        end

        // Write while busy is ignored; reset mid-frame releases the lines.
        wr(PS2TX_DATA, 32'h55);
        wait_rts(inh, ok);
        check("busy_rts", {31'b0, ok}, 32'h1);
        dev_run(20, 3, 1'b1, 0, fr);
        wr(PS2TX_DATA, 32'h12);
        rd(PS2TX_DATA, v);
        check("busy_wr_ignored", v, 32'h55);
        check("busy_still", {31'b0, busy}, 32'h1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_lines", {29'b0, busy, kclk_oe, kdata_oe}, 32'h0);
        rst = 1'b0;
        rd(PS2TX_DATA, v);
        check("midrst_data", v, 32'h0);
        rd(PS2TX_STAT, v);
        check("midrst_stat", v, 32'h0);

        // Unmapped address: reads 0, write starts nothing.
        wr(3'd5, 32'hFF);
        check("unmapped_wr", {31'b0, busy}, 32'h0);
        rd(3'd5, v);
        check("unmapped_rd", v, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
